mips_multicycle_ctrl_fsm: RTL and testbench
===========================================

// Module: mips_multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle main control unit of the non-pipelined MIPS core. Decodes the opcode and sequences
//  each instruction through one-hot states; drives the 6-bit state bus consumed by the ALU control and
//  ALU datapath (ALU control samples in ALUCTL=6'b000100, ALU computes in EXEC=6'b001000), plus ALUop
//  and all datapath enables. Waits on a ready handshake from memory for instruction fetch and data access.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter
// PORTS
//  clk           in   1      single system clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  opcode        in   6      instr[31:26] from IR, valid from DECODE onward
//  zero          in   1      ALU zero flag, valid in EXEC
//  mem_ready     in   1      memory completes current access this cycle
//  state         out  6      one-hot state bus
//  ALUop         out  2      00 add (lw/sw), 01 sub (beq), 10 R-type funct
//  ir_write      out  1      load IR
//  pc_write      out  1      unconditional PC update
//  pc_src        out  2      00 PC+4, 01 branch target, 10 jump target
//  branch_taken  out  1      PC update from beq
//  mem_read      out  1      memory read request
//  mem_write     out  1      memory write request
//  iord          out  1      0 address=PC, 1 address=ALU result
//  reg_write     out  1      register file write enable
//  reg_dst       out  1      1 rd (R-type), 0 rt (lw)
//  mem_to_reg    out  1      1 writeback from MDR, 0 from ALU result
//  alu_src       out  1      1 sign-extended immediate, 0 rt
//  illegal_op    out  1      one-cycle pulse on unsupported opcode
//  retired       out  CNT_W  completed instruction count
// BEHAVIOUR
//  - States: FETCH=000001 DECODE=000010 ALUCTL=000100 EXEC=001000 MEM=010000 WB=100000.
//  - Reset: state=FETCH, retired=0; all other outputs are decoded from state and are 0 in FETCH
//    with mem_ready=0, except mem_read=1 and iord=0.
//  - FETCH: mem_read=1, iord=0; hold while mem_ready=0. With mem_ready=1: ir_write=1,
//    pc_write=1, pc_src=00 (same cycle, combinational), next DECODE.
//  - DECODE: R(000000), lw(100011), sw(101011), beq(000100) -> ALUCTL; any other -> illegal_op=1,
//    next FETCH, retired unchanged.
//  - ALUCTL/EXEC: ALUop and alu_src held constant through both states and MEM (registered at DECODE
//    exit): R 10/0, lw 00/1, sw 00/1, beq 01/0.
//  - EXEC: R -> WB; lw/sw -> MEM; beq -> FETCH with branch_taken=zero, pc_src=01 in that cycle.
//  - MEM: iord=1; lw mem_read=1, sw mem_write=1; hold while mem_ready=0. With mem_ready=1:
//    lw -> WB, sw -> FETCH.
//  - WB: reg_write=1 for one cycle; R reg_dst=1 mem_to_reg=0; lw reg_dst=0 mem_to_reg=1; next FETCH.
//  - retired increments by 1 on every transition into FETCH except from DECODE (illegal), wraps
//    at 2^CNT_W-1 -> 0.
//  - mem_ready sampled only in FETCH and MEM; ignored elsewhere. zero sampled only in EXEC.
//  - Latency (mem_ready=1 always): R 5 cycles, lw 6, sw 5, beq 4, illegal 2.
//  - reset asserted in any state: state->FETCH immediately (async), retired->0, in-flight access
//    abandoned; no write strobe may assert while reset=1.
//  - state is always exactly one-hot; unreachable encodings recover to FETCH next cycle.
// CONFIGURATION
//  MIPS_JUMP_EN defined: opcode 000010 (j) is legal; in DECODE pc_write=1, pc_src=10, next FETCH,
//    retired increments (latency 2).
//  MIPS_JUMP_EN undefined: 000010 treated as illegal (illegal_op pulse, no PC write, no count).
// TESTING
//  - reset mid-MEM of sw with mem_ready=0 -> state=000001 same cycle, mem_write=0, retired=0.
//  - add (op 000000), mem_ready=1 -> states 01,02,04,08,20,01 (hex); ALUop=10 in 04/08; reg_write=1
//    only in WB; retired=1.
//  - lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_read=1 iord=1 throughout,
//    then WB with mem_to_reg=1 reg_dst=0; total 9 cycles.
//  - beq zero=1 -> branch_taken=1 pc_src=01 in EXEC, back to FETCH after 4 cycles; zero=0 ->
//    branch_taken=0; retired increments in both.
//  - opcode 111000 -> illegal_op=1 one cycle in DECODE, FETCH next, retired unchanged; opcode
//    000010 -> jump with MIPS_JUMP_EN, illegal without.
//  - Preload retired=2^CNT_W-1 (force), complete one sw -> retired=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_fsm
//
// Main control unit of the multi-cycle (non-pipelined) MIPS core. It decodes
// the opcode held in IR and steps each instruction through a one-hot state
// sequence:
//
//   FETCH -> DECODE -> ALUCTL -> EXEC -> [MEM] -> [WB] -> FETCH
//
// The one-hot state is exported so the ALU control (samples in ALUCTL) and
// the ALU datapath (computes in EXEC) can key off it directly. Every other
// output is decoded from the current state, the registered instruction class
// and the memory ready handshake.
//
// Optional feature (compile-time macro):
//   MIPS_JUMP_EN  - when defined, opcode 000010 (j) is legal. It completes in
//                   DECODE with pc_write=1, pc_src=10 and counts as retired.
//                   When undefined, 000010 decodes as an illegal opcode.
//
// Parameters:
//   CNT_W         width of the retired-instruction counter
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   opcode[5:0]   instr[31:26] from IR, valid from DECODE onward
//   zero          ALU zero flag, used in EXEC only
//   mem_ready     memory completes current access; used in FETCH and MEM only
//   state[5:0]    one-hot state bus
//   ALUop[1:0]    00 add, 01 sub, 10 R-type funct (ALUCTL, EXEC, MEM)
//   ir_write      load IR
//   pc_write      unconditional PC update
//   pc_src[1:0]   00 PC+4, 01 branch target, 10 jump target
//   branch_taken  PC update from beq
//   mem_read      memory read request
//   mem_write     memory write request
//   iord          0 address=PC, 1 address=ALU result
//   reg_write     register file write enable
//   reg_dst       1 rd, 0 rt
//   mem_to_reg    1 writeback from MDR, 0 from ALU result
//   alu_src       1 sign-extended immediate, 0 rt
//   illegal_op    one-cycle pulse on an unsupported opcode
//   retired       completed instruction count (wraps)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [5:0]       state,
    output logic [1:0]       ALUop,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             branch_taken,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [5:0] {
        S_FETCH  = 6'b000001,
        S_DECODE = 6'b000010,
        S_ALUCTL = 6'b000100,
        S_EXEC   = 6'b001000,
        S_MEM    = 6'b010000,
        S_WB     = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_LW  = 2'd1,
        CLS_SW  = 2'd2,
        CLS_BEQ = 2'd3
    } cls_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef MIPS_JUMP_EN
    localparam logic [5:0] OP_J   = 6'b000010;
`endif

    state_t           state_reg, state_next;
    cls_t             cls_reg, cls_next;
    logic [1:0]       aluop_reg, aluop_next;
    logic             alu_src_reg, alu_src_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire_inc;

    // Strobes that modify architectural state, before reset gating.
    logic ir_write_raw;
    logic pc_write_raw;
    logic branch_raw;
    logic mem_write_raw;
    logic reg_write_raw;

    // -----------------------------------------------------------------------
    // State and decode registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            cls_reg     <= CLS_R;
            aluop_reg   <= 2'b00;
            alu_src_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cls_reg     <= cls_next;
            aluop_reg   <= aluop_next;
            alu_src_reg <= alu_src_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (retire_inc) begin
            retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cls_next      = cls_reg;
        aluop_next    = aluop_reg;
        alu_src_next  = alu_src_reg;
        retire_inc    = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        pc_src        = 2'b00;
        mem_read      = 1'b0;
        iord          = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_next   = S_DECODE;
                end
            end

            S_DECODE: begin
                // Class, ALUop and alu_src are captured on DECODE exit so that
                // they stay stable even if IR-derived opcode changes later.
                case (opcode)
                    OP_R: begin
                        cls_next     = CLS_R;
                        aluop_next   = 2'b10;
                        alu_src_next = 1'b0;
                        state_next   = S_ALUCTL;
                    end
                    OP_LW: begin
                        cls_next     = CLS_LW;
                        aluop_next   = 2'b00;
                        alu_src_next = 1'b1;
                        state_next   = S_ALUCTL;
                    end
                    OP_SW: begin
                        cls_next     = CLS_SW;
                        aluop_next   = 2'b00;
                        alu_src_next = 1'b1;
                        state_next   = S_ALUCTL;
                    end
                    OP_BEQ: begin
                        cls_next     = CLS_BEQ;
                        aluop_next   = 2'b01;
                        alu_src_next = 1'b0;
                        state_next   = S_ALUCTL;
                    end
`ifdef MIPS_JUMP_EN
                    OP_J: begin
                        pc_write_raw = 1'b1;
                        pc_src       = 2'b10;
                        retire_inc   = 1'b1;
                        state_next   = S_FETCH;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_ALUCTL: begin
                state_next = S_EXEC;
            end

            S_EXEC: begin
                case (cls_reg)
                    CLS_R:          state_next = S_WB;
                    CLS_LW, CLS_SW: state_next = S_MEM;
                    default: begin
                        pc_src     = 2'b01;
                        branch_raw = zero;
                        retire_inc = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                iord          = 1'b1;
                mem_read      = (cls_reg == CLS_LW);
                mem_write_raw = (cls_reg == CLS_SW);
                if (mem_ready) begin
                    if (cls_reg == CLS_SW) begin
                        retire_inc = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = (cls_reg == CLS_R);
                mem_to_reg    = (cls_reg == CLS_LW);
                retire_inc    = 1'b1;
                state_next    = S_FETCH;
            end

            // Any non-one-hot encoding falls back to FETCH.
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign state   = state_reg;
    assign retired = retired_reg;

    // ALUop / alu_src are only meaningful while the ALU is in use.
    always_comb begin
        ALUop   = 2'b00;
        alu_src = 1'b0;
        if (state_reg == S_ALUCTL || state_reg == S_EXEC || state_reg == S_MEM) begin
            ALUop   = aluop_reg;
            alu_src = alu_src_reg;
        end
    end

    // Reset forces FETCH asynchronously, but FETCH with mem_ready=1 would
    // still raise ir_write/pc_write; gating keeps every write strobe low
    // for the whole reset pulse.
    assign ir_write     = ir_write_raw  & ~reset;
    assign pc_write     = pc_write_raw  & ~reset;
    assign branch_taken = branch_raw    & ~reset;
    assign mem_write    = mem_write_raw & ~reset;
    assign reg_write    = reg_write_raw & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl_fsm
//
// Self-checking bench for mips_multicycle_ctrl_fsm. A table of instruction
// records (opcode, handshake stalls and expected per-instruction totals) is
// pushed to a scoreboard queue as each instruction is launched and popped
// when the FSM returns to FETCH; observed totals are compared against it.
// Hand-written sequences cover reset, the add state trace, the retired
// counter wrap and reset in the middle of a stalled store.
// Honours MIPS_JUMP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl_fsm;

    localparam int CNT_W = 32;
    localparam logic [5:0] ST_F = 6'h01;
    localparam logic [5:0] ST_D = 6'h02;
    localparam logic [5:0] ST_A = 6'h04;
    localparam logic [5:0] ST_E = 6'h08;
    localparam logic [5:0] ST_M = 6'h10;
    localparam logic [5:0] ST_W = 6'h20;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic [5:0]       state;
    logic [1:0]       ALUop;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             branch_taken;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .state        (state),
        .ALUop        (ALUop),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .iord         (iord),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .illegal_op   (illegal_op),
        .retired      (retired)
    );

    // Per-instruction record: stimulus, then expected totals over the
    // instruction (counts are numbers of cycles the signal was high).
    typedef struct {
        int opcode;
        int zero;
        int fetch_wait;   // cycles of mem_ready=0 in FETCH
        int mem_wait;     // cycles of mem_ready=0 in MEM
        int cycles;       // total cycles FETCH..last state
        int aluop;        // ALUop required in ALUCTL/EXEC/MEM
        int alu_src;
        int branch;       // cycles with branch_taken=1
        int pcsrc_nz;     // cycles with pc_src != 00
        int pc_w;         // cycles with pc_write=1
        int reg_w;        // cycles with reg_write=1
        int m2r;          // mem_to_reg while reg_write
        int rdst;         // reg_dst while reg_write
        int mem_rd;       // mem_read cycles outside FETCH
        int mem_wr;
        int iord_n;
        int illegal;
        int ret;          // retired increment
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    vec_t exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string what, input int idx, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", what, idx, act, exp);
        end
    endtask

    // Runs one instruction from FETCH (called right after a falling edge).
    task automatic run_instr(input int idx, input vec_t v);
        vec_t             e;
        int               cyc = 0, fw = 0, mw = 0;
        int               aluop_bad = 0, fetch_bad = 0, onehot_bad = 0;
        int               ir_w = 0, pc_w = 0, reg_w = 0, mem_rd = 0, mem_wr = 0;
        int               iord_n = 0, ill = 0, pcsrc_nz = 0, br = 0;
        int               m2r = 0, rdst = 0;
        logic [CNT_W-1:0] ret0;
        logic [CNT_W-1:0] dret;
        logic [5:0]       st;
        bit               left = 0, done = 0;

        exp_q.push_back(v);
        ret0 = retired;
        for (int k = 0; k < 64 && !done; k++) begin
            st = state;
            opcode = (st == ST_F || st == ST_D) ? 6'(v.opcode) : 6'($urandom);
            zero   = (st == ST_E) ? 1'(v.zero) : 1'($urandom);
            if (st == ST_F) begin
                mem_ready = (fw >= v.fetch_wait);
                fw++;
            end else if (st == ST_M) begin
                mem_ready = (mw >= v.mem_wait);
                mw++;
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            cyc++;
            if ($countones(state) != 1) onehot_bad++;
            if (st == ST_F) begin
                if (mem_read !== 1'b1 || iord !== 1'b0 || ALUop !== 2'b00 ||
                    alu_src !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0 ||
                    illegal_op !== 1'b0 || branch_taken !== 1'b0 || pc_src !== 2'b00 ||
                    ir_write !== mem_ready || pc_write !== mem_ready)
                    fetch_bad++;
            end else begin
                left = 1;
                if (mem_read) mem_rd++;
            end
            if (st == ST_A || st == ST_E || st == ST_M) begin
                if (int'(ALUop) != v.aluop || int'(alu_src) != v.alu_src) aluop_bad++;
            end
            if (ir_write)     ir_w++;
            if (pc_write)     pc_w++;
            if (mem_write)    mem_wr++;
            if (iord)         iord_n++;
            if (illegal_op)   ill++;
            if (branch_taken) br++;
            if (pc_src != 2'b00) pcsrc_nz++;
            if (reg_write) begin
                reg_w++;
                m2r  = int'(mem_to_reg);
                rdst = int'(reg_dst);
            end
            @(negedge clk);
            if (left && state == ST_F) done = 1;
        end
        if (!done) check("completion_timeout", idx, 0, 1);

        e = exp_q.pop_front();
        dret = retired - ret0;
        check("cycles",        idx, cyc,        e.cycles);
        check("aluop_alusrc",  idx, aluop_bad,  0);
        check("fetch_outputs", idx, fetch_bad,  0);
        check("onehot",        idx, onehot_bad, 0);
        check("ir_write",      idx, ir_w,       1);
        check("pc_write",      idx, pc_w,       e.pc_w);
        check("branch_taken",  idx, br,         e.branch);
        check("pc_src",        idx, pcsrc_nz,   e.pcsrc_nz);
        check("reg_write",     idx, reg_w,      e.reg_w);
        check("mem_to_reg",    idx, m2r,        e.m2r);
        check("reg_dst",       idx, rdst,       e.rdst);
        check("mem_read",      idx, mem_rd,     e.mem_rd);
        check("mem_write",     idx, mem_wr,     e.mem_wr);
        check("iord",          idx, iord_n,     e.iord_n);
        check("illegal_op",    idx, ill,        e.illegal);
        check("retired_delta", idx, int'(dret), e.ret);
        $display("instr vec %0d op=%06b cycles=%0d retired=%0d", idx, 6'(v.opcode), cyc, retired);
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [5:0] add_trace [6];

    initial begin
        //          op        z fw mw cyc alu src br pcs pcw rw m2r rd mrd mwr io ill ret
        vecs[0]  = '{'b000000, 0, 0, 0, 5,  2,  0,  0, 0,  1,  1, 0,  1, 0,  0,  0, 0,  1};
        vecs[1]  = '{'b000000, 1, 2, 0, 7,  2,  0,  0, 0,  1,  1, 0,  1, 0,  0,  0, 0,  1};
        vecs[2]  = '{'b100011, 0, 0, 0, 6,  0,  1,  0, 0,  1,  1, 1,  0, 1,  0,  1, 0,  1};
        vecs[3]  = '{'b100011, 1, 0, 3, 9,  0,  1,  0, 0,  1,  1, 1,  0, 4,  0,  4, 0,  1};
        vecs[4]  = '{'b101011, 0, 0, 0, 5,  0,  1,  0, 0,  1,  0, 0,  0, 0,  1,  1, 0,  1};
        vecs[5]  = '{'b101011, 0, 1, 2, 8,  0,  1,  0, 0,  1,  0, 0,  0, 0,  3,  3, 0,  1};
        vecs[6]  = '{'b000100, 1, 0, 0, 4,  1,  0,  1, 1,  1,  0, 0,  0, 0,  0,  0, 0,  1};
        vecs[7]  = '{'b000100, 0, 0, 0, 4,  1,  0,  0, 1,  1,  0, 0,  0, 0,  0,  0, 0,  1};
        vecs[8]  = '{'b111000, 0, 0, 0, 2,  0,  0,  0, 0,  1,  0, 0,  0, 0,  0,  0, 1,  0};
        vecs[9]  = '{'b001000, 0, 1, 0, 3,  0,  0,  0, 0,  1,  0, 0,  0, 0,  0,  0, 1,  0};
`ifdef MIPS_JUMP_EN
        vecs[10] = '{'b000010, 0, 0, 0, 2,  0,  0,  0, 1,  2,  0, 0,  0, 0,  0,  0, 0,  1};
`else
        vecs[10] = '{'b000010, 0, 0, 0, 2,  0,  0,  0, 0,  1,  0, 0,  0, 0,  0,  0, 1,  0};
`endif
        vecs[11] = '{'b100011, 0, 0, 1, 7,  0,  1,  0, 0,  1,  1, 1,  0, 2,  0,  2, 0,  1};

        add_trace[0] = ST_F; add_trace[1] = ST_D; add_trace[2] = ST_A;
        add_trace[3] = ST_E; add_trace[4] = ST_W; add_trace[5] = ST_F;

        // ---------------- reset state ----------------
        reset = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        #12;
        check("reset_state",     0, state,     ST_F);
        check("reset_retired",   0, retired,   0);
        check("reset_mem_read",  0, mem_read,  1);
        check("reset_iord",      0, iord,      0);
        check("reset_aluop",     0, ALUop,     0);
        check("reset_reg_write", 0, reg_write, 0);
        mem_ready = 1'b1;
        #1;
        check("reset_ir_write_gated", 0, ir_write, 0);
        check("reset_pc_write_gated", 0, pc_write, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("post_reset_state", 0, state, ST_F);
        @(negedge clk);

        // ---------------- retired counter wrap ----------------
        force dut.retired_reg = '1;
        #1;
        release dut.retired_reg;
        check("wrap_preload", 100, retired, 64'hFFFF_FFFF);
        run_instr(100, vecs[4]);
        check("wrap_to_zero", 100, retired, 0);

        // ---------------- add state trace ----------------
        for (int i = 0; i < 5; i++) begin
            check("add_trace_state", 200 + i, state, add_trace[i]);
            opcode = 6'b000000;
            mem_ready = 1'b1;
            #1;
            check("add_reg_write", 200 + i, reg_write, (i == 4) ? 1 : 0);
            if (i == 2 || i == 3) check("add_aluop", 200 + i, ALUop, 2);
            @(negedge clk);
        end
        check("add_trace_state", 205, state, add_trace[5]);
        check("add_retired", 205, retired, 1);
        $display("add trace done retired=%0d", retired);

        // ---------------- table-driven instructions ----------------
        for (int i = 0; i < NV; i++) begin
            run_instr(i, vecs[i]);
        end

        // ---------------- reset in the middle of a stalled sw ----------------
        opcode = 6'b101011;
        mem_ready = 1'b1;
        check("sw_rst_fetch", 300, state, ST_F);
        @(negedge clk);
        check("sw_rst_decode", 300, state, ST_D);
        @(negedge clk);
        check("sw_rst_aluctl", 300, state, ST_A);
        @(negedge clk);
        check("sw_rst_exec", 300, state, ST_E);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sw_rst_mem", 300, state, ST_M);
        check("sw_rst_mem_write_before", 300, mem_write, 1);
        @(negedge clk);
        check("sw_rst_mem_held", 300, state, ST_M);
        check("sw_rst_retired_nonzero", 300, (retired != 0) ? 1 : 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("sw_rst_state",     300, state,     ST_F);
        check("sw_rst_mem_write", 300, mem_write, 0);
        check("sw_rst_retired",   300, retired,   0);
        check("sw_rst_mem_read",  300, mem_read,  1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("sw_rst_after_release", 300, state, ST_F);
        $display("reset mid-MEM sequence done state=%02h retired=%0d", state, retired);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
